// File: rtl/booth_mul_seq_if.sv
// booth_mul_seq_if
//   Handshake and operand/result bundle for the iterative Booth multiplier.
//   master : issue side  (drives start/m/q, observes busy/done/product)
//   slave  : multiplier  (observes start/m/q, drives busy/done/product)
//   Signals:
//     start    request a multiply (sampled only when not busy)
//     m, q     signed multiplicand / multiplier, WIDTH bits
//     busy     engine iterating
//     done     one-cycle product-valid pulse
//     product  signed 2*WIDTH-bit result, held until the next done
interface booth_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, m, q, input busy, done, product);
  modport slave  (input start, m, q, output busy, done, product);
endinterface

// File: rtl/booth_mul_seq.sv
// booth_mul_seq
//   Radix-4 (modified Booth) signed multiplier retiring one recoded digit per
//   clock. WIDTH/2 RUN cycles per multiply, then a one-cycle DONE pulse.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset (aborts any operation in flight)
//     bus    booth_mul_seq_if.slave : start/m/q in, busy/done/product out
//   WIDTH must be even and >= 4; the product is 2*WIDTH bits.
module booth_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  booth_mul_seq_if.slave       bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int STEPS = WIDTH / 2;
  localparam int CW    = $clog2(STEPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;

  // Multiplicand is held sign-extended and pre-shifted: each step moves it
  // left by two so that it always carries the 2*count weight of the current
  // digit. Likewise the multiplier shifts right by two, keeping the current
  // Booth triplet {q[2i+1], q[2i], q[2i-1]} in bits [2:0].
  logic [PW-1:0]   mcand_q;
  logic [WIDTH:0]  mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   product_q;

  logic [2:0]      trip;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_nxt;
  logic            last;
  logic            load;

  assign trip    = mplier_q[2:0];
  assign last    = (count_q == CW'(STEPS - 1));
  assign load    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign acc_nxt = acc_q + pp;

  // Booth recode: partial product = digit * M, digit in {-2,-1,0,+1,+2}.
  always_comb begin
    pp = '0;
    case (trip)
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      S_RUN:   bus.busy = 1'b1;
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  assign bus.product = product_q;

  // ---------------- Datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else if (load) begin
      mcand_q  <= {{WIDTH{bus.m[WIDTH-1]}}, bus.m};
      mplier_q <= {bus.q, 1'b0};
      acc_q    <= '0;
      count_q  <= '0;
    end else if (state_q == S_RUN) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_q << 2;
      mplier_q <= mplier_q >> 2;
      count_q  <= count_q + CW'(1);
      if (last) product_q <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
module tb_booth_mul_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  booth_mul_seq_if #(.WIDTH(W)) bus ();
  booth_mul_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  // Reference: plain signed 64-bit multiplication.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start for one edge; returns positioned just after the sampling edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.m     = a;
    bus.q     = b;
    step();
    bus.start = 1'b0;
  endtask

  // Edges until done is seen (bounded), and how many of those samples had busy.
  task automatic wait_done(output int k, output int nb);
    k = 0;
    nb = 0;
    while (bus.done !== 1'b1 && k < 40) begin
      if (bus.busy === 1'b1) nb++;
      step();
      k++;
    end
  endtask

  initial begin
    int k, nb, d0;
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic [W-1:0] pm, pq, nm, nq;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.m     = '0;
    bus.q     = '0;
    step();
    step();
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_prod", bus.product, 64'd0);
    reset = 1'b0;
    step();

    // 1: basic multiply with latency and busy-length checks
    start_op(32'd3, 32'd5);
    wait_done(k, nb);
    chk("t1_latency", 64'(k), 64'd16);
    chk("t1_busy_cycles", 64'(nb), 64'd16);
    chk("t1_prod", bus.product, 64'd15);
    step();
    chk("t1_done_pulse", 64'(bus.done), 64'd0);
    chk("t1_prod_hold", bus.product, 64'd15);

    // 2/3: directed values and corners
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF;
    ta[1] = -32'sd7;       tb[1] = 32'd6;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000;
    ta[3] = 32'h7FFF_FFFF; tb[3] = 32'h8000_0000;
    ta[4] = 32'd0;         tb[4] = $urandom;
    ta[5] = 32'h8000_0000; tb[5] = 32'h7FFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(k, nb);
      chk($sformatf("t23_lat_%0d", i), 64'(k), 64'd16);
      chk($sformatf("t23_prod_%0d", i), bus.product, ref_mul(ta[i], tb[i]));
    end
    chk("t2_const_m1", ref_mul(ta[0], tb[0]), 64'h0000_0000_0000_0001);
    chk("t2_const_42", ref_mul(ta[1], tb[1]), 64'hFFFF_FFFF_FFFF_FFD6);
    chk("t3_const_min", ref_mul(ta[2], tb[2]), 64'h4000_0000_0000_0000);
    chk("t3_const_mix", ref_mul(ta[3], tb[3]), 64'hC000_0000_8000_0000);

    // 4: start and operand changes during RUN are ignored
    start_op(32'd1234, -32'sd99);
    for (int i = 0; i < 5; i++) step();
    bus.start = 1'b1; bus.m = 32'hDEAD_BEEF; bus.q = 32'h1357_9BDF;
    step();
    bus.start = 1'b0; bus.m = 32'h0BAD_F00D; bus.q = 32'h2468_ACE0;
    wait_done(k, nb);
    chk("t4_latency", 64'(k + 6), 64'd16);
    chk("t4_prod", bus.product, ref_mul(32'd1234, -32'sd99));
    // start held in the DONE cycle launches a new run on the next edge
    start_op(32'h0001_0001, 32'hFFFF_0003);
    chk("t4_b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(k, nb);
    chk("t4_b2b_lat", 64'(k), 64'd16);
    chk("t4_b2b_prod", bus.product, ref_mul(32'h0001_0001, 32'hFFFF_0003));
    step();

    // 5: reset mid-run aborts without a done pulse
    start_op(32'd77, 32'd88);
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_done", 64'(bus.done), 64'd0);
    chk("t5_prod", bus.product, 64'd0);
    reset = 1'b0;
    d0 = done_cnt;
    for (int i = 0; i < 25; i++) step();
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    start_op(-32'sd12345, 32'd6789);
    wait_done(k, nb);
    chk("t5_fresh_lat", 64'(k), 64'd16);
    chk("t5_fresh_prod", bus.product, ref_mul(-32'sd12345, 32'd6789));
    step();

    // 6: random back-to-back
    d0 = done_cnt;
    pm = $urandom;
    pq = $urandom;
    start_op(pm, pq);
    for (int i = 0; i < 1000; i++) begin
      wait_done(k, nb);
      chk($sformatf("t6_prod_%0d", i), bus.product, ref_mul(pm, pq));
      if (i < 999) begin
        nm = $urandom;
        nq = $urandom;
        start_op(nm, nq);
        pm = nm;
        pq = nq;
      end
    end
    step();
    step();
    chk("t6_done_count", 64'(done_cnt - d0), 64'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
